lsu: RTL and testbench

LSU -- requirements
Module: lsu

---
 rtl/lsu_pkg.sv | 38 +++
 rtl/lsu_lane.sv | 51 +++++
 rtl/lsu.sv | 118 +++++++++++
 tb/tb_lsu.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared constants, state encoding and request legality check for the LSU.
package lsu_pkg;

    // RV32I load/store width codes (funct3)
    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;
    localparam logic [2:0] SB  = 3'b000;
    localparam logic [2:0] SH  = 3'b001;
    localparam logic [2:0] SW  = 3'b010;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD   = 3'd1,
        LDW  = 3'd2,
        WR   = 3'd3,
        RESP = 3'd4
    } state_t;

    // True when the request can never reach memory: bad width code or misaligned.
    function automatic logic req_bad(input logic store, input logic [2:0] funct3,
                                     input logic [1:0] addr_lo);
        logic illegal;
        logic misaligned;
        if (store)
            illegal = !(funct3 == SB || funct3 == SH || funct3 == SW);
        else
            illegal = !(funct3 == LB || funct3 == LH || funct3 == LW ||
                        funct3 == LBU || funct3 == LHU);
        // funct3[1:0] encodes size for both loads and stores: 01=half, 10=word
        misaligned = ((funct3[1:0] == 2'b01) && addr_lo[0]) ||
                     ((funct3[1:0] == 2'b10) && (addr_lo != 2'b00));
        return illegal || misaligned;
    endfunction

endpackage

// File: rtl/lsu_lane.sv
// Byte/half lane handling: load extraction with extension, and sub-word store merge.
module lsu_lane
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] load_data,
    input  logic [31:0] wdata,
    output logic [31:0] load_ext,
    output logic [31:0] merged
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    // Pick the addressed lane and extend it according to the width code
    always_comb begin
        lane_b   = 8'h00;
        lane_h   = addr_lo[1] ? load_data[31:16] : load_data[15:0];
        case (addr_lo)
            2'd0:    lane_b = load_data[7:0];
            2'd1:    lane_b = load_data[15:8];
            2'd2:    lane_b = load_data[23:16];
            default: lane_b = load_data[31:24];
        endcase
        case (funct3)
            LB:      load_ext = {{24{lane_b[7]}}, lane_b};
            LBU:     load_ext = {24'h0, lane_b};
            LH:      load_ext = {{16{lane_h[15]}}, lane_h};
            LHU:     load_ext = {16'h0, lane_h};
            default: load_ext = load_data;
        endcase
    end

    // Replace only the addressed lane of the old word for SB/SH
    always_comb begin
        merged = load_data;
        if (funct3 == SB) begin
            case (addr_lo)
                2'd0:    merged[7:0]   = wdata[7:0];
                2'd1:    merged[15:8]  = wdata[7:0];
                2'd2:    merged[23:16] = wdata[7:0];
                default: merged[31:24] = wdata[7:0];
            endcase
        end else if (funct3 == SH) begin
            if (addr_lo[1]) merged[31:16] = wdata[15:0];
            else            merged[15:0]  = wdata[15:0];
        end
    end

endmodule

// File: rtl/lsu.sv
// Load/store unit: one request at a time against a word-wide synchronous memory.
// Sub-word stores are done as read-modify-write.
module lsu
    import lsu_pkg::*;
#(
    parameter int ADDR_WIDTH = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_store,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        is_load,
    output logic        is_store,
    output logic [31:0] mem_addr,
    output logic [31:0] store_data,
    input  logic [31:0] load_data
);

    state_t                state, state_next;
    logic                  store_q;
    logic [2:0]            f3_q;
    logic [ADDR_WIDTH+1:0] addr_q;
    logic [31:0]           wdata_q;
    logic                  err_q;
    logic [31:0]           rdata_q;
    logic [31:0]           sdata_q;
    logic                  accept;
    logic                  bad;
    logic [31:0]           load_ext;
    logic [31:0]           merged;
    logic                  unused_addr_hi;

    // Address bits above the memory's word index are dropped, so accesses wrap
    assign unused_addr_hi = ^req_addr[31:ADDR_WIDTH+2];

    assign req_ready = (state == IDLE) && !rst;
    assign accept    = req_valid && req_ready;
    assign bad       = req_bad(req_store, req_funct3, req_addr[1:0]);

    lsu_lane u_lane (
        .funct3    (f3_q),
        .addr_lo   (addr_q[1:0]),
        .load_data (load_data),
        .wdata     (wdata_q),
        .load_ext  (load_ext),
        .merged    (merged)
    );

    // Outputs are forced low combinationally during reset so a reset that
    // lands in WR suppresses the write in that same cycle.
    assign is_load    = !rst && (state == RD);
    assign is_store   = !rst && (state == WR);
    assign resp_valid = !rst && (state == RESP);
    assign resp_err   = resp_valid && err_q;
    assign resp_rdata = rst ? 32'h0 : rdata_q;
    assign store_data = rst ? 32'h0 : sdata_q;
    assign mem_addr   = rst ? 32'h0
                            : {{(32-ADDR_WIDTH){1'b0}}, addr_q[ADDR_WIDTH+1:2]};

    // State register plus request capture and result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            store_q <= 1'b0;
            f3_q    <= 3'b0;
            addr_q  <= '0;
            wdata_q <= 32'h0;
            err_q   <= 1'b0;
            rdata_q <= 32'h0;
            sdata_q <= 32'h0;
        end else begin
            state <= state_next;
            if (accept) begin
                store_q <= req_store;
                f3_q    <= req_funct3;
                addr_q  <= req_addr[ADDR_WIDTH+1:0];
                wdata_q <= req_wdata;
                err_q   <= bad;
                sdata_q <= req_wdata;
                // errors go straight to RESP, so the zero result shows with resp_valid
                if (bad) rdata_q <= 32'h0;
            end
            // result registers change only on the edge into RESP
            if (state == LDW) begin
                if (store_q) sdata_q <= merged;
                else         rdata_q <= load_ext;
            end
            if (state == WR) rdata_q <= 32'h0;
        end
    end

    // Next-state sequencing
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (bad)                                state_next = RESP;
                    else if (req_store && req_funct3 == SW) state_next = WR;
                    else                                    state_next = RD;
                end
            end
            RD:      state_next = LDW;
            LDW:     state_next = store_q ? WR : RESP;
            WR:      state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu: vector table plus reset and back-to-back sequences.
module tb_lsu;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        is_load;
    logic        is_store;
    logic [31:0] mem_addr;
    logic [31:0] store_data;
    logic [31:0] load_data;

    logic [31:0] mem [0:32767];
    logic        pre_we = 1'b0;
    logic [14:0] pre_addr = '0;
    logic [31:0] pre_data = '0;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    lsu #(.ADDR_WIDTH(15)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .is_load(is_load), .is_store(is_store), .mem_addr(mem_addr),
        .store_data(store_data), .load_data(load_data)
    );

    // Word memory with one-cycle read latency and a bench preload port
    always @(posedge clk) begin
        if (pre_we)   mem[pre_addr] <= pre_data;
        if (is_store) mem[mem_addr[14:0]] <= store_data;
        if (is_load)  load_data <= mem[mem_addr[14:0]];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic poke(input logic [14:0] a, input logic [31:0] d);
        pre_we = 1'b1; pre_addr = a; pre_data = d;
        @(negedge clk);
        pre_we = 1'b0;
    endtask

    typedef struct {
        logic        st;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] init;
        logic [31:0] rdata;
        logic        err;
        logic [31:0] word;
        int          lat;
        int          nld;
        int          nst;
        logic [31:0] maddr;
    } vec_t;

    vec_t v[15];

    // One request from IDLE; called at a negedge
    task automatic run_vec(input int k, input vec_t t);
        int nld = 0, nst = 0, lat = 0, got = 0, both = 0;
        logic [31:0] la = '0, sa = '0, sd = '0, rd = '0;
        logic        er = 1'b0;
        logic [14:0] widx;
        string       tag;
        tag  = $sformatf("v%0d", k);
        widx = t.addr[16:2];
        poke(widx, t.init);
        req_valid = 1'b1; req_store = t.st; req_funct3 = t.f3;
        req_addr = t.addr; req_wdata = t.wdata;
        chk({tag, " ready"}, {31'h0, req_ready}, 32'h1);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0; req_wdata = 32'h0; req_addr = 32'hFFFF_FFFF;
        for (int c = 1; c <= 20; c++) begin
            if (is_load)  begin nld++; la = mem_addr; end
            if (is_store) begin nst++; sa = mem_addr; sd = store_data; end
            if (is_load && is_store) both = 1;
            if (resp_valid) begin got = 1; lat = c; rd = resp_rdata; er = resp_err; break; end
            @(negedge clk);
        end
        chk({tag, " resp seen"}, got, 1);
        chk({tag, " latency"}, lat, t.lat);
        chk({tag, " rdata"}, rd, t.rdata);
        chk({tag, " err"}, {31'h0, er}, {31'h0, t.err});
        chk({tag, " loads"}, nld, t.nld);
        chk({tag, " stores"}, nst, t.nst);
        chk({tag, " both strobes"}, both, 0);
        if (t.nld > 0) chk({tag, " load addr"}, la, t.maddr);
        if (t.nst > 0) begin
            chk({tag, " store addr"}, sa, t.maddr);
            chk({tag, " store data"}, sd, t.word);
        end
        chk({tag, " mem word"}, mem[widx], t.word);
        @(negedge clk);
        chk({tag, " valid drop"}, {31'h0, resp_valid}, 32'h0);
        chk({tag, " rdata hold"}, resp_rdata, t.rdata);
    endtask

    initial begin
        logic [31:0] res [2];
        int nres, busy, acc2, seen;

        v[0]  = '{1'b0, 3'b000, 32'h0000_0103, 32'h0, 32'h80FF_1234, 32'hFFFF_FF80, 1'b0, 32'h80FF_1234, 3, 1, 0, 32'h40};
        v[1]  = '{1'b0, 3'b100, 32'h0000_0103, 32'h0, 32'h80FF_1234, 32'h0000_0080, 1'b0, 32'h80FF_1234, 3, 1, 0, 32'h40};
        v[2]  = '{1'b0, 3'b001, 32'h0000_0102, 32'h0, 32'h80FF_1234, 32'hFFFF_80FF, 1'b0, 32'h80FF_1234, 3, 1, 0, 32'h40};
        v[3]  = '{1'b0, 3'b101, 32'h0000_0100, 32'h0, 32'h80FF_1234, 32'h0000_1234, 1'b0, 32'h80FF_1234, 3, 1, 0, 32'h40};
        v[4]  = '{1'b0, 3'b010, 32'h0000_0100, 32'h0, 32'h80FF_1234, 32'h80FF_1234, 1'b0, 32'h80FF_1234, 3, 1, 0, 32'h40};
        v[5]  = '{1'b0, 3'b000, 32'h0000_0101, 32'h0, 32'h80FF_1234, 32'h0000_0012, 1'b0, 32'h80FF_1234, 3, 1, 0, 32'h40};
        v[6]  = '{1'b1, 3'b001, 32'h0000_0002, 32'hAAAA_BEEF, 32'h1122_3344, 32'h0, 1'b0, 32'hBEEF_3344, 4, 1, 1, 32'h0};
        v[7]  = '{1'b1, 3'b000, 32'h0000_0001, 32'h0000_0055, 32'h1122_3344, 32'h0, 1'b0, 32'h1122_5544, 4, 1, 1, 32'h0};
        v[8]  = '{1'b1, 3'b010, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0000_0000, 32'h0, 1'b0, 32'hDEAD_BEEF, 2, 0, 1, 32'h4};
        v[9]  = '{1'b0, 3'b010, 32'h0000_0006, 32'h0, 32'h1234_5678, 32'h0, 1'b1, 32'h1234_5678, 1, 0, 0, 32'h0};
        v[10] = '{1'b0, 3'b011, 32'h0000_0100, 32'h0, 32'h80FF_1234, 32'h0, 1'b1, 32'h80FF_1234, 1, 0, 0, 32'h0};
        v[11] = '{1'b1, 3'b001, 32'h0000_0003, 32'h0000_FFFF, 32'h1122_3344, 32'h0, 1'b1, 32'h1122_3344, 1, 0, 0, 32'h0};
        v[12] = '{1'b1, 3'b100, 32'h0000_0000, 32'h0000_FFFF, 32'h1122_3344, 32'h0, 1'b1, 32'h1122_3344, 1, 0, 0, 32'h0};
        v[13] = '{1'b0, 3'b001, 32'h0000_0101, 32'h0, 32'h80FF_1234, 32'h0, 1'b1, 32'h80FF_1234, 1, 0, 0, 32'h0};
        v[14] = '{1'b0, 3'b010, 32'h0002_0100, 32'h0, 32'h80FF_1234, 32'h80FF_1234, 1'b0, 32'h80FF_1234, 3, 1, 0, 32'h40};

        // Reset: outputs low and requests ignored even with req_valid high
        rst = 1'b1; req_valid = 1'b1; req_store = 1'b1; req_funct3 = 3'b010;
        req_addr = 32'h10; req_wdata = 32'h5555_5555;
        repeat (3) @(negedge clk);
        chk("rst ready", {31'h0, req_ready}, 32'h0);
        chk("rst resp_valid", {31'h0, resp_valid}, 32'h0);
        chk("rst resp_err", {31'h0, resp_err}, 32'h0);
        chk("rst rdata", resp_rdata, 32'h0);
        chk("rst strobes", {30'h0, is_load, is_store}, 32'h0);
        chk("rst mem_addr", mem_addr, 32'h0);
        chk("rst store_data", store_data, 32'h0);
        req_valid = 1'b0; rst = 1'b0;
        @(negedge clk);
        chk("post-rst ready", {31'h0, req_ready}, 32'h1);

        for (int k = 0; k < 15; k++) run_vec(k, v[k]);

        // SB with reset in LDW: abandoned, memory untouched
        poke(15'd8, 32'h0102_0304);
        req_valid = 1'b1; req_store = 1'b1; req_funct3 = 3'b000;
        req_addr = 32'h20; req_wdata = 32'hFF;
        @(posedge clk); @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);                       // now in LDW
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        for (int c = 0; c < 5; c++) begin
            if (is_store || resp_valid) seen++;
            @(negedge clk);
        end
        chk("ldw-rst strobes", seen, 0);
        chk("ldw-rst mem", mem[8], 32'h0102_0304);
        chk("ldw-rst ready", {31'h0, req_ready}, 32'h1);

        // SW with reset in WR: store suppressed immediately
        poke(15'd12, 32'hCAFE_0000);
        req_valid = 1'b1; req_store = 1'b1; req_funct3 = 3'b010;
        req_addr = 32'h30; req_wdata = 32'h1111_2222;
        @(posedge clk); @(negedge clk);
        req_valid = 1'b0;
        chk("wr is_store", {31'h0, is_store}, 32'h1);
        rst = 1'b1;
        #1 chk("wr-rst is_store", {31'h0, is_store}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        for (int c = 0; c < 5; c++) begin
            if (is_store || resp_valid) seen++;
            @(negedge clk);
        end
        chk("wr-rst strobes", seen, 0);
        chk("wr-rst mem", mem[12], 32'hCAFE_0000);

        // Back-to-back loads with req_valid held
        poke(15'h50, 32'h0000_AAAA);
        poke(15'h51, 32'h0000_BBBB);
        req_valid = 1'b1; req_store = 1'b0; req_funct3 = 3'b010; req_addr = 32'h140;
        @(posedge clk); @(negedge clk);
        req_addr = 32'h144;
        nres = 0; busy = 0; acc2 = 0;
        for (int c = 0; c < 20 && nres < 2; c++) begin
            if (resp_valid) begin res[nres] = resp_rdata; nres++; end
            if (acc2 == 1) req_valid = 1'b0;
            else if (req_ready) acc2 = 1;
            else busy++;
            @(negedge clk);
        end
        req_valid = 1'b0;
        chk("b2b responses", nres, 2);
        chk("b2b busy cycles", busy, 3);
        chk("b2b first", res[0], 32'h0000_AAAA);
        chk("b2b second", res[1], 32'h0000_BBBB);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
        $finish;
    end

endmodule
